// File: rtl/i2s_frame_packer_if.sv
// Stream bundle around the I2S frame packer: the PHY word stream going in
// and the AXI-Stream master going out.
// The master modport is the packer's view and the slave modport is its environment.
interface i2s_frame_packer_if;
  logic        s_axis_tvalid;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [4:0]  m_axis_tuser;
  logic        m_axis_tlast;

  modport master (
    input  s_axis_tvalid,
    input  s_axis_tdata,
    input  s_axis_tlast,
    input  m_axis_tready,
    output m_axis_tvalid,
    output m_axis_tdata,
    output m_axis_tuser,
    output m_axis_tlast
  );

  modport slave (
    output s_axis_tvalid,
    output s_axis_tdata,
    output s_axis_tlast,
    output m_axis_tready,
    input  m_axis_tvalid,
    input  m_axis_tdata,
    input  m_axis_tuser,
    input  m_axis_tlast
  );
endinterface

// File: rtl/i2s_frame_packer.sv
// I2S frame packer: formats PHY words to 32-bit containers and tags them with
// their TDM slot. Whole frames are admitted into a FIFO or dropped atomically.
// The FIFO is presented on a ready/valid master.
// Input words are registered once, then counted, formatted and admitted.
// The FIFO head is held in output registers, so every stream output is a flop.
module i2s_frame_packer #(
  parameter int DEPTH = 64
) (
  input  logic                bclk,
  input  logic                rst_n,
  i2s_frame_packer_if.master  bus,
  input  logic [5:0]          i_word_width,
  input  logic [4:0]          i_tdm_num,
  input  logic [1:0]          i_format,
  output logic [15:0]         o_drop_count,
  output logic [15:0]         o_frame_err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (CW > 6) ? CW : 6;
  localparam int EW = 38;   // {last, user[4:0], data[31:0]}

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_DROP = 1'b1
  } adm_state_e;

  // Zero-extend, sign-extend from bit w-1, or left-justify to bit 31.
  function automatic logic [31:0] format_sample(input logic [31:0] d,
                                                input logic [5:0]  w,
                                                input logic [1:0]  f);
    logic [31:0] mask;
    logic        sign;
    logic [31:0] r;
    mask = (w >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    sign = d[5'(w - 6'd1)];
    case (f)
      2'b00:   r = d & mask;
      2'b01:   r = (d & mask) | (sign ? ~mask : 32'd0);
      default: r = d << (6'd32 - w);
    endcase
    return r;
  endfunction

  // Saturating event counter step.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic          in_valid_q;
  logic [31:0]   in_data_q;
  logic          in_last_q;
  logic [4:0]    ch_q, ch_d;
  logic [4:0]    nm1_q, nm1_d;
  logic [5:0]    w_q, w_d;
  logic [1:0]    fmt_q, fmt_d;
  adm_state_e    state_q, state_d;
  logic [15:0]   drop_q, err_q;
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, remain_s;
  logic          m_valid_q, m_valid_d;
  logic [EW-1:0] m_entry_q, m_entry_d;

  logic [4:0]    live_nm1_s, cur_nm1_s;
  logic [5:0]    live_w_s, cur_w_s;
  logic [1:0]    cur_fmt_s;
  logic          frame_start_s, at_end_s, store_last_s, frame_err_s;
  logic [EW-1:0] wr_entry_s;
  logic [FW-1:0] need_s, free_s;
  logic          do_read_s, admit_s, wr_en_s, drop_evt_s;

  // Register the incoming PHY word; this stage sets the one-cycle latency.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
      in_data_q  <= 32'd0;
      in_last_q  <= 1'b0;
    end else begin
      in_valid_q <= bus.s_axis_tvalid;
      in_data_q  <= bus.s_axis_tdata;
      in_last_q  <= bus.s_axis_tlast;
    end
  end

  // Frame-start words use the live configuration; later words use the latched copy.
  always_comb begin
    live_nm1_s    = i_tdm_num - 5'd1;   // 0 wraps to 31, i.e. 32 slots
    live_w_s      = ((i_word_width == 6'd0) || (i_word_width > 6'd32)) ? 6'd32 : i_word_width;
    frame_start_s = in_valid_q && (ch_q == 5'd0);
    if (frame_start_s) begin
      cur_nm1_s = live_nm1_s;
      cur_w_s   = live_w_s;
      cur_fmt_s = i_format;
    end else begin
      cur_nm1_s = nm1_q;
      cur_w_s   = w_q;
      cur_fmt_s = fmt_q;
    end
    at_end_s     = (ch_q == cur_nm1_s);
    store_last_s = in_last_q || at_end_s;
    frame_err_s  = in_valid_q && (in_last_q != at_end_s);
    wr_entry_s   = {store_last_s, ch_q, format_sample(in_data_q, cur_w_s, cur_fmt_s)};
    do_read_s    = m_valid_q && bus.m_axis_tready;
    need_s       = FW'({1'b0, cur_nm1_s}) + FW'(1'b1);
    free_s       = FW'(DEPTH) - FW'(count_q) + FW'(do_read_s);
    admit_s      = (free_s >= need_s);
  end

  // Slot counter advance and configuration latch.
  always_comb begin
    ch_d  = ch_q;
    nm1_d = nm1_q;
    w_d   = w_q;
    fmt_d = fmt_q;
    if (in_valid_q) begin
      ch_d = store_last_s ? 5'd0 : ch_q + 5'd1;
    end else begin
      ch_d = ch_q;
    end
    if (frame_start_s) begin
      nm1_d = live_nm1_s;
      w_d   = live_w_s;
      fmt_d = i_format;
    end else begin
      nm1_d = nm1_q;
    end
  end

  // Slot counter and latched configuration registers.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q  <= 5'd0;
      nm1_q <= 5'd0;
      w_q   <= 6'd32;
      fmt_q <= 2'b00;
    end else begin
      ch_q  <= ch_d;
      nm1_q <= nm1_d;
      w_q   <= w_d;
      fmt_q <= fmt_d;
    end
  end

  // Admission state register.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PASS;
    end else begin
      state_q <= state_d;
    end
  end

  // Admission next state: decided only on a frame-start word.
  always_comb begin
    state_d = state_q;
    if (frame_start_s) begin
      state_d = admit_s ? ST_PASS : ST_DROP;
    end else begin
      state_d = state_q;
    end
  end

  // Admission outputs: write strobe and drop event.
  always_comb begin
    wr_en_s    = 1'b0;
    drop_evt_s = 1'b0;
    if (frame_start_s) begin
      wr_en_s    = admit_s;
      drop_evt_s = !admit_s;
    end else begin
      case (state_q)
        ST_PASS: wr_en_s = in_valid_q;
        ST_DROP: wr_en_s = 1'b0;
        default: wr_en_s = 1'b0;
      endcase
    end
  end

  // Saturating drop and frame-error counters.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 16'd0;
      err_q  <= 16'd0;
    end else begin
      drop_q <= drop_evt_s ? sat_inc16(drop_q) : drop_q;
      err_q  <= frame_err_s ? sat_inc16(err_q) : err_q;
    end
  end

  // FIFO pointer and occupancy next state, plus the next head word.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(wr_en_s);
    rd_ptr_d  = rd_ptr_q + AW'(do_read_s);
    count_d   = count_q + CW'(wr_en_s) - CW'(do_read_s);
    remain_s  = count_q - CW'(do_read_s);
    m_valid_d = (count_d != {CW{1'b0}});
    if (count_d == {CW{1'b0}}) begin
      m_entry_d = {EW{1'b0}};
    end else if (wr_en_s && (remain_s == {CW{1'b0}})) begin
      m_entry_d = wr_entry_s;     // word written into an empty slot becomes the head
    end else begin
      m_entry_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are invalidated by the pointers on reset.
  always_ff @(posedge bclk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  // Registered head of the FIFO driving the stream outputs.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_entry_q <= {EW{1'b0}};
    end else begin
      m_valid_q <= m_valid_d;
      m_entry_q <= m_entry_d;
    end
  end

  assign bus.m_axis_tvalid = m_valid_q;
  assign bus.m_axis_tdata  = m_entry_q[31:0];
  assign bus.m_axis_tuser  = m_entry_q[36:32];
  assign bus.m_axis_tlast  = m_entry_q[37];
  assign o_drop_count      = drop_q;
  assign o_frame_err_count = err_q;

endmodule

// File: tb/tb_i2s_frame_packer.sv
// Bench for i2s_frame_packer: directed scenarios plus a randomized phase.
// A queue-based reference model predicts outputs and counters.
module tb_i2s_frame_packer;
  localparam int DEPTH = 8;

  logic        bclk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  ww;
  logic [4:0]  tdm;
  logic [1:0]  fmt;
  logic [15:0] drop_cnt, err_cnt;

  i2s_frame_packer_if bus();

  i2s_frame_packer #(.DEPTH(DEPTH)) dut (
    .bclk              (bclk),
    .rst_n             (rst_n),
    .bus               (bus),
    .i_word_width      (ww),
    .i_tdm_num         (tdm),
    .i_format          (fmt),
    .o_drop_count      (drop_cnt),
    .o_frame_err_count (err_cnt)
  );

  always #5 bclk = ~bclk;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  u;
    logic        l;
  } word_t;

  int    checks = 0;
  int    errors = 0;
  word_t mq[$];
  int    m_ch, m_n, m_w, m_f, m_drops, m_errs;
  bit    m_pass;
  bit    p_valid, p_last;
  logic [31:0] p_data;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference formatting with plain arithmetic on the sample value.
  function automatic logic [31:0] fmt_ref(logic [31:0] d, int w, int f);
    longint unsigned span = 64'd1 << w;
    longint unsigned low  = {32'd0, d} % span;
    longint unsigned r;
    if (f == 0) r = low;
    else if (f == 1) r = d[w-1] ? low + (64'h1_0000_0000 - span) : low;
    else r = low << (32 - w);
    return r[31:0];
  endfunction

  // Reference treatment of one input word given the free space at its write edge.
  task automatic model_word(logic [31:0] d, bit l, int free);
    bit    at_end;
    word_t w;
    if (m_ch == 0) begin
      m_n    = (tdm == 5'd0) ? 32 : int'(tdm);
      m_w    = (ww == 6'd0 || ww > 6'd32) ? 32 : int'(ww);
      m_f    = int'(fmt);
      m_pass = (free >= m_n);
      if (!m_pass && m_drops < 65535) m_drops++;
    end
    at_end = (m_ch == m_n - 1);
    if (l != at_end && m_errs < 65535) m_errs++;
    if (m_pass) begin
      w.d = fmt_ref(d, m_w, m_f);
      w.u = 5'(m_ch);
      w.l = l || at_end;
      mq.push_back(w);
    end
    m_ch = (l || at_end) ? 0 : m_ch + 1;
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic cyc(bit v, logic [31:0] d, bit l, bit rdy);
    bit rd;
    int free;
    bus.s_axis_tvalid = v;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    bus.m_axis_tready = rdy;
    chk("tvalid", bus.m_axis_tvalid, mq.size() != 0);
    rd = (mq.size() != 0) && rdy;
    if (rd) begin
      chk("tdata", bus.m_axis_tdata, mq[0].d);
      chk("tuser", bus.m_axis_tuser, mq[0].u);
      chk("tlast", bus.m_axis_tlast, mq[0].l);
    end
    chk("drop_count", drop_cnt, m_drops);
    chk("err_count", err_cnt, m_errs);
    free = DEPTH - mq.size() + (rd ? 1 : 0);
    if (rd) void'(mq.pop_front());
    if (p_valid) model_word(p_data, p_last, free);
    p_valid = v;
    p_data  = d;
    p_last  = l;
    @(posedge bclk);
    #1;
  endtask

  task automatic frame(int len, bit last_at_end, bit rdy);
    for (int k = 0; k < len; k++) cyc(1'b1, $urandom, (k == len - 1) && last_at_end, rdy);
  endtask

  task automatic idle(int n, bit rdy);
    for (int k = 0; k < n; k++) cyc(1'b0, 32'd0, 1'b0, rdy);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tvalid", bus.m_axis_tvalid, 32'd0);
    chk("rst_tdata", bus.m_axis_tdata, 32'd0);
    chk("rst_tuser", bus.m_axis_tuser, 32'd0);
    chk("rst_tlast", bus.m_axis_tlast, 32'd0);
    chk("rst_drop", drop_cnt, 32'd0);
    chk("rst_err", err_cnt, 32'd0);
    mq.delete();
    m_ch = 0; m_n = 1; m_w = 32; m_f = 0; m_pass = 1'b1;
    m_drops = 0; m_errs = 0; p_valid = 1'b0;
    @(posedge bclk);
    #1 rst_n = 1'b1;
    @(posedge bclk);
    #1;
  endtask

  initial begin
    int d0, e0, n, len, r, nn;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = 32'd0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = 1'b0;
    ww = 6'd32; tdm = 5'd2; fmt = 2'b00;
    @(posedge bclk);
    #1;
    do_reset();

    // Sign-extend stereo, one-cycle latency.
    ww = 6'd24; tdm = 5'd2; fmt = 2'b01;
    cyc(1'b1, 32'h0080_0000, 1'b0, 1'b1);
    cyc(1'b1, 32'h007F_FFFF, 1'b1, 1'b1);
    chk("se_w0_valid", bus.m_axis_tvalid, 32'd1);
    chk("se_w0_data", bus.m_axis_tdata, 32'hFF80_0000);
    chk("se_w0_user", bus.m_axis_tuser, 32'd0);
    chk("se_w0_last", bus.m_axis_tlast, 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("se_w1_data", bus.m_axis_tdata, 32'h007F_FFFF);
    chk("se_w1_user", bus.m_axis_tuser, 32'd1);
    chk("se_w1_last", bus.m_axis_tlast, 32'd1);
    idle(2, 1'b1);

    // Left-justify, then full-width passthrough in all formats.
    ww = 6'd16; tdm = 5'd1; fmt = 2'b10;
    cyc(1'b1, 32'h0000_1234, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("lj_data", bus.m_axis_tdata, 32'h1234_0000);
    idle(2, 1'b1);
    for (int f = 0; f < 3; f++) begin
      ww = 6'd32; fmt = 2'(f);
      cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      cyc(1'b0, 32'd0, 1'b0, 1'b0);
      chk("w32_pass", bus.m_axis_tdata, 32'hDEAD_BEEF);
      idle(2, 1'b1);
    end

    // Backpressure: two frames fill the FIFO, the third is dropped whole.
    tdm = 5'd4; ww = 6'd32; fmt = 2'b00;
    d0 = m_drops;
    for (int f = 0; f < 3; f++) frame(4, 1'b1, 1'b0);
    idle(1, 1'b0);
    chk("bp_drop", drop_cnt, d0 + 1);
    n = 0;
    for (int i = 0; i < 20 && bus.m_axis_tvalid; i++) begin
      chk("bp_user_seq", bus.m_axis_tuser, n % 4);
      cyc(1'b0, 32'd0, 1'b0, 1'b1);
      n++;
    end
    chk("bp_drained", n, 32'd8);
    frame(4, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("bp_drop_hold", drop_cnt, d0 + 1);

    // Short frame: tlast on the third of four slots.
    e0 = m_errs;
    frame(3, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("short_err", err_cnt, e0 + 1);
    frame(4, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Boundary: admission counts a read completing at the frame-start edge.
    d0 = m_drops;
    tdm = 5'd1;
    for (int f = 0; f < 5; f++) frame(1, 1'b1, 1'b0);
    idle(1, 1'b0);
    tdm = 5'd4;
    cyc(1'b1, $urandom, 1'b0, 1'b0);
    cyc(1'b1, $urandom, 1'b0, 1'b1);
    cyc(1'b1, $urandom, 1'b0, 1'b0);
    cyc(1'b1, $urandom, 1'b1, 1'b0);
    idle(1, 1'b0);
    chk("bnd_admit", drop_cnt, d0);
    idle(3, 1'b1);
    frame(4, 1'b1, 1'b0);
    idle(1, 1'b0);
    chk("bnd_drop", drop_cnt, d0 + 1);
    idle(12, 1'b1);

    // Reset in the middle of a partially queued frame.
    tdm = 5'd4;
    frame(3, 1'b0, 1'b0);
    idle(1, 1'b0);
    do_reset();
    frame(4, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Randomized frames, configurations, gaps and backpressure.
    for (int f = 0; f < 40; f++) begin
      idle(1, 1'($urandom));
      nn  = $urandom_range(1, 8);
      tdm = 5'(nn);
      ww  = 6'($urandom_range(0, 40));
      fmt = 2'($urandom);
      r   = $urandom_range(0, 9);
      len = (r == 0) ? $urandom_range(1, nn) : nn;
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) cyc(1'b0, 32'd0, 1'b0, 1'($urandom));
        cyc(1'b1, $urandom, (k == len - 1) && (r != 1), 1'($urandom));
      end
    end
    idle(30, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end
endmodule
